// File: rtl/iic_wrbyte.sv
// Byte-transmit stage of the SHT21 I2C controller.
// Shifts one DW-bit byte MSB-first onto SDA in step with the shared SCL
// phase strobes, releases SDA for the ACK slot, samples the slave ACK and
// reports done/ack_err to the controller.
module iic_wrbyte #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] data_in,
   input  logic          scl_hc,
   input  logic          scl_ls,
   input  logic          scl_lc,
   inout  wire           sda,
   output logic          busy,
   output logic          done,
   output logic          ack_err
);

   localparam int            CW      = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BIT  = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [DW-1:0] shift_q, shift_nx;
   logic [CW-1:0] bit_cnt, bit_cnt_nx;
   logic          sda_oe, sda_oe_nx;
   logic          sda_r, sda_r_nx;
   logic          busy_nx, done_nx, ack_err_nx;

   // Open-drain style pin: only the registered enable/value reach the line,
   // so a reset releases SDA without waiting for a clock edge.
   assign sda = sda_oe ? sda_r : 1'bz;

   // State and output registers; every output leaves the block registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift_q <= '0;
         bit_cnt <= CNT_TOP;
         sda_oe  <= 1'b0;
         sda_r   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
      end else begin
         state   <= state_nx;
         shift_q <= shift_nx;
         bit_cnt <= bit_cnt_nx;
         sda_oe  <= sda_oe_nx;
         sda_r   <= sda_r_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         ack_err <= ack_err_nx;
      end
   end

   // Next-state and next-output logic. Only one strobe action is taken per
   // cycle, with priority scl_lc > scl_hc > scl_ls; abort overrides all.
   always_comb begin
      state_nx   = state;
      shift_nx   = shift_q;
      bit_cnt_nx = bit_cnt;
      sda_oe_nx  = sda_oe;
      sda_r_nx   = sda_r;
      done_nx    = 1'b0;
      ack_err_nx = ack_err;

      if (abort) begin
         // Drop the transfer; ack_err and the latched byte are left alone.
         state_nx  = IDLE;
         sda_oe_nx = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_nx   = data_in;
                  bit_cnt_nx = CNT_TOP;
                  state_nx   = BIT;
               end
            end
            BIT: begin
               if (scl_lc) begin
                  // Change data only in the middle of SCL low.
                  sda_oe_nx = 1'b1;
                  sda_r_nx  = shift_q[bit_cnt];
               end else if (scl_hc) begin
                  // Data held stable through SCL high.
                  sda_r_nx = sda_r;
               end else if (scl_ls) begin
                  if (bit_cnt == '0) begin
                     state_nx = ACK;
                  end else begin
                     bit_cnt_nx = bit_cnt - 1'b1;
                  end
               end
            end
            ACK: begin
               if (scl_lc) begin
                  // Hand the line to the slave for its ACK bit.
                  sda_oe_nx = 1'b0;
               end else if (scl_hc) begin
                  // Low = ACK, high (pull-up) = NACK.
                  ack_err_nx = sda;
               end else if (scl_ls) begin
                  // SDA stays released so the STOP stage can take over.
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end
            default: begin
               state_nx  = IDLE;
               sda_oe_nx = 1'b0;
            end
         endcase
      end

      // busy follows the next state, so it drops in the same cycle done rises.
      busy_nx = (state_nx != IDLE);
   end

endmodule

// File: doc/iic_wrbyte.md
Name: iic_wrbyte

Overview:
- Byte-transmit stage of the SHT21 I2C controller; sits directly upstream of the STOP stage.
- Shifts one DW-bit byte (address+R/W, or command) MSB-first onto SDA, aligned to the SCL phase strobes produced by the shared SCL generator.
- Releases SDA for the ACK slot, samples the slave ACK, and reports done/ack_err to the controller.
- The controller then launches the next byte or the STOP stage.

Parameters:
- DW, 8, bits per transfer (data bits before the ACK slot); legal range 1..8.

Ports:
- clk  input  1  100 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; accepted only in IDLE
- abort  input  1  synchronous abort; returns to IDLE, no done
- data_in  input  DW  byte to send; latched on accepted start
- scl_hc  input  1  one-cycle strobe at centre of SCL high
- scl_ls  input  1  one-cycle strobe at start of SCL low (falling edge)
- scl_lc  input  1  one-cycle strobe at centre of SCL low
- sda  inout  1  I2C data; driven only when internal sda_oe=1, else 1'bz
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle pulse at end of ACK slot
- ack_err  output  1  sampled ACK level (1 = NACK); valid from done until next accepted start

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, sda_oe=0 (sda=z), sda_r=1, busy=0, done=0, ack_err=0, shift register=0, bit_cnt=DW-1.
- States: IDLE, BIT, ACK.
- IDLE:
  - start=1 latches data_in into the shift register and sets bit_cnt=DW-1.
  - Next cycle: state=BIT, busy=1.
  - Strobes are ignored in IDLE.
- BIT:
  - scl_lc: sda_oe=1, sda_r=shift[bit_cnt].
  - scl_hc: no change; data is held stable through SCL high.
  - scl_ls: if bit_cnt==0, state=ACK; else bit_cnt decrements.
  - The first bit is driven on the first scl_lc after acceptance. The caller issues start while SCL is low and before that phase's scl_lc; otherwise the bit is driven at the next scl_lc.
- ACK:
  - scl_lc: sda_oe=0 (release).
  - scl_hc: ack_err <= sda (registered pin value).
  - scl_ls: done=1 for exactly one cycle, busy=0, state=IDLE.
  - sda_oe stays 0 at exit, so the STOP stage takes over the line cleanly.
- Latency: done asserts in the cycle after the (DW+1)-th scl_ls following acceptance.
- Strobe collision: if strobes coincide in one cycle, priority is scl_lc > scl_hc > scl_ls, and only the winning action is taken.
- start while busy: ignored; the latched data is not disturbed.
- start and abort in the same cycle: abort wins and start is dropped.
- abort (any state): next cycle state=IDLE, busy=0, sda_oe=0, done=0. ack_err and the shift register are unchanged.
- Mid-transfer reset: immediate, to the reset values; sda is released asynchronously.
- Outputs are registered. sda is a combinational tri-state of the registered sda_oe and sda_r.
- done and busy are never high in the same cycle.

Test Plan:
- DW=8, start with data_in=8'h80 (SHT21 write address), slave pulls sda=0 at ACK scl_hc:
  - SDA at successive scl_hc reads 1,0,0,0,0,0,0,0.
  - sda=z from the 9th scl_lc.
  - done pulses once after the 9th scl_ls; ack_err=0; busy falls in the same cycle.
- data_in=8'hE3, no slave drive (pull-up=1) at ACK:
  - Bits 1,1,1,0,0,0,1,1 on the line.
  - ack_err=1 at done.
- Second start with data_in=8'h00 issued after 3rd scl_ls of an 8'hA5 transfer:
  - Remaining bits still follow 8'hA5.
  - Exactly one done.
- abort asserted one cycle after the 4th scl_lc of 8'h5A:
  - Next cycle sda=z, busy=0, state IDLE.
  - No done.
  - A new start then sends 8'h5A cleanly from the MSB.
- rst_n driven low mid-ACK slot: sda=z and busy=0 immediately (asynchronous), done never pulses, ack_err=0.
- scl_lc and scl_ls asserted in the same cycle during BIT: only the scl_lc action is taken (bit driven, bit_cnt unchanged).
